// File: rtl/demux_1to4_pkg.sv
// Shared constants and types for the 1-to-4 demultiplexer slice.
package demux_1to4_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_OUT = 4;

  // Output select index; bit 1 is the MSB (S1), bit 0 the LSB (S0).
  typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_1to4_pkg

// File: rtl/demux_decode_2to4.sv
// Combinational 2-to-4 one-hot decoder with enable.
// The mask is all-zero when en is low and one-hot otherwise.
module demux_decode_2to4
  import demux_1to4_pkg::*;
(
  input  sel_t               sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] mask
);

  logic [NUM_OUT-1:0] onehot;

  // Decode the select index into a one-hot vector.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (sel == sel_t'(i)) onehot[i] = 1'b1;
    end
  end

  // AND with the replicated enable so an unknown enable reaches the mask.
  always_comb begin
    mask = onehot & {NUM_OUT{en}};
  end

endmodule : demux_decode_2to4

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer with registered outputs.
// A is routed to D[{S1,S0}] when Enable is high; every other output is 0.
// All outputs come straight from flops, one cycle after the inputs.
module demux_1to4
  import demux_1to4_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic              S0,
  input  logic              S1,
  input  logic              Enable,
  output logic [DATA_W-1:0] D0,
  output logic [DATA_W-1:0] D1,
  output logic [DATA_W-1:0] D2,
  output logic [DATA_W-1:0] D3
);

  logic [NUM_OUT-1:0] mask;
  logic [DATA_W-1:0]  d_next [NUM_OUT];
  logic [DATA_W-1:0]  d_q    [NUM_OUT];

  demux_decode_2to4 u_decode (
    .sel  ({S1, S0}),
    .en   (Enable),
    .mask (mask)
  );

  // Gate the data with each decoder lane so unselected outputs load zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      d_next[i] = A & {DATA_W{mask[i]}};
    end
  end

  // Output registers; synchronous reset overrides all routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        d_q[i] <= d_next[i];
      end
    end
  end

  assign D0 = d_q[0];
  assign D1 = d_q[1];
  assign D2 = d_q[2];
  assign D3 = d_q[3];

endmodule : demux_1to4

// File: tb/tb_demux_1to4.sv
// Scoreboard bench for demux_1to4: a driver issues stimulus and queues the
// expected outputs; a monitor pops and compares after every rising edge.
module tb_demux_1to4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A;
  logic         S0, S1, Enable;
  logic [W-1:0] D0, D1, D2, D3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [4*W-1:0] exp_q [$];
  logic [4*W-1:0] prev_exp;
  bit             have_prev = 1'b0;

  demux_1to4 #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .S0     (S0),
    .S1     (S1),
    .Enable (Enable),
    .D0     (D0),
    .D1     (D1),
    .D2     (D2),
    .D3     (D3)
  );

  always #5 clk = ~clk;

  wire [4*W-1:0] dout = {D3, D2, D1, D0};

  task automatic check(input string name, input logic [4*W-1:0] act,
                       input logic [4*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the outputs form four W-bit lanes; only lane sel may hold A.
  function automatic logic [4*W-1:0] model(input bit r, input logic [W-1:0] a,
                                           input int unsigned sel, input bit en);
    logic [4*W-1:0] v;
    v = '0;
    if (!r && en) v[sel*W +: W] = a;
    return v;
  endfunction

  task automatic drive(input bit r, input logic [W-1:0] a,
                       input int unsigned sel, input bit en);
    logic [1:0] s;
    @(negedge clk);
    s      = 2'(sel);
    rst    = r;
    A      = a;
    S1     = s[1];
    S0     = s[0];
    Enable = en;
    #1;
    if (have_prev) check("no_comb_path", dout, prev_exp);
    prev_exp  = model(r, a, sel, en);
    have_prev = 1'b1;
    exp_q.push_back(prev_exp);
  endtask

  // Monitor: each rising edge produces exactly one new output word.
  initial begin
    logic [4*W-1:0] e;
    int unsigned    nz;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", dout, e);
        nz = 0;
        for (int k = 0; k < 4; k++) if (dout[k*W +: W] != '0) nz++;
        n_checks++;
        if (nz > 1) begin
          n_fail++;
          $display("FAIL onehot_or_zero: got %0d nonzero outputs expected at most 1 (%h)", nz, dout);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned fsel;
    rst = 1'b1; A = '0; S0 = 1'b0; S1 = 1'b0; Enable = 1'b0;

    // Reset with arbitrary inputs.
    drive(1, W'($urandom), $urandom_range(3), 1);
    drive(1, W'($urandom), $urandom_range(3), 1);
    // Disabled, then each select value with A=1.
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    drive(0, 1, 2, 1);
    drive(0, 1, 1, 1);
    drive(0, 1, 3, 1);
    // Mid-operation reset, then recovery on D3.
    drive(1, 1, 3, 1);
    drive(0, 1, 3, 1);
    // A toggling with each select held fixed.
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 6; k++)
        drive(0, W'($urandom), s, 1);
    // A=0 while enabled.
    drive(0, 0, 2, 1);
    // Random run.
    for (int k = 0; k < 400; k++) begin
      fsel = $urandom_range(3);
      drive(($urandom_range(19) == 0), W'($urandom), fsel, ($urandom_range(3) != 0));
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux_1to4
